// File: rtl/lut4_cfg_loader.sv
// Runtime-programmable bank of LUT4 cells loaded from a byte stream.
// A complete, well-formed frame is committed atomically; anything else is discarded.
module lut4_cfg_loader #(
  parameter int unsigned NumLuts = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [7:0]             cfg_data_i,
  input  logic                   cfg_last_i,
  input  logic [4*NumLuts-1:0]   lut_in_i,
  output logic [NumLuts-1:0]     lut_out_o,
  output logic [2*NumLuts-1:0]   lut_class_o,
  output logic                   cfg_done_o,
  output logic                   cfg_err_o
);

  localparam int unsigned NumBytes = 2 * NumLuts;
  localparam int unsigned CntW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int unsigned CfgW     = 16 * NumLuts;

  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StCommit, StErr} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [CfgW-1:0]        shadow_q;
  logic [CfgW-1:0]        active_q;
  logic [NumLuts-1:0]     lut_out_q;
  logic [2*NumLuts-1:0]   lut_class_q;
  logic [NumLuts-1:0]     lut_eval;
  logic [2*NumLuts-1:0]   class_d;
  logic                   xfer;
  logic                   last_idx;
  logic                   shadow_we;

  assign xfer     = cfg_valid_i & cfg_ready_o;
  assign last_idx = (cnt_q == CntW'(NumBytes - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_we = 1'b0;
    unique case (state_q)
      StIdle, StLoad: begin
        if (xfer) begin
          shadow_we = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (last_idx) begin
            state_d = cfg_last_i ? StCommit : StDrain;
          end else begin
            state_d = cfg_last_i ? StErr : StLoad;
          end
        end
      end
      StDrain: begin
        if (xfer && cfg_last_i) begin
          state_d = StErr;
        end
      end
      StCommit, StErr: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore outputs: the loader stalls for the single commit/discard cycle
  always_comb begin
    cfg_ready_o = 1'b1;
    cfg_done_o  = 1'b0;
    cfg_err_o   = 1'b0;
    unique case (state_q)
      StCommit: begin
        cfg_ready_o = 1'b0;
        cfg_done_o  = 1'b1;
      end
      StErr: begin
        cfg_ready_o = 1'b0;
        cfg_err_o   = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < NumLuts; g++) begin : g_lut
    logic [15:0] init;
    assign init           = active_q[16*g +: 16];
    assign lut_eval[g]    = init[lut_in_i[4*g +: 4]];
    // Output with all inputs tied together: bit 15 when high, bit 0 when low
    assign class_d[2*g +: 2] = {shadow_q[16*g + 15], shadow_q[16*g]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q    <= '0;
      active_q    <= '0;
      lut_class_q <= '0;
      lut_out_q   <= '0;
    end else begin
      if (shadow_we) begin
        shadow_q[{cnt_q, 3'b000} +: 8] <= cfg_data_i;
      end
      if (state_q == StCommit) begin
        active_q    <= shadow_q;
        lut_class_q <= class_d;
      end
      lut_out_q <= lut_eval;
    end
  end

  assign lut_out_o   = lut_out_q;
  assign lut_class_o = lut_class_q;

endmodule
